pmod_enc_gen: RTL and testbench
===============================

Name: pmod_enc_gen

Overview:
- Quadrature rotary-encoder signal generator: transmit side of the Pmod ENC interface that our encoder readers (x/y/colour position counters) decode.
- Accepts step commands (direction, count) over a valid/ready handshake and drives A/B quadrature, button and switch lines.
- Drives the same 4-bit pin group the readers sample (JA/JC/JD[7:4]).
- Used on-board as a loopback stimulus source and in simulation as the encoder model.

Parameters:
- STEP_DIV, 1000: clk cycles between consecutive quadrature transitions; legal range 2..65535.
- CNT_WIDTH, 8: width of the step-count field.
- BOUNCE_CYC, 4: glitch spacing in clk cycles (only with ENC_BOUNCE_EN); requires 3*BOUNCE_CYC < STEP_DIV.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_dir  in  1  1 = CW, 0 = CCW.
- cmd_steps  in  CNT_WIDTH  number of detents to emit.
- btn_in  in  1  requested button level.
- sw_in  in  1  requested switch level.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse when a command completes.
- enc_out  out  4  bit0 = A, bit1 = B, bit2 = BTN, bit3 = SWT (maps to pins [4..7]).

Behaviour:
- Reset (rst=0 at a clk edge):
  - enc_out = 4'b0000, cmd_ready = 1, busy = 0, done = 0.
  - Divider, step counter and phase cleared; FSM = IDLE.
  - Applies identically mid-command; the command is abandoned with no done pulse.
- Handshake:
  - Command accepted on the clk edge where cmd_valid && cmd_ready.
  - cmd_dir and cmd_steps are latched at that edge; later input changes are ignored until the next accept.
  - While busy, cmd_ready = 0 and cmd_valid is ignored (no queuing).
- FSM states IDLE, RUN, FINISH:
  - IDLE -> RUN on accept when cmd_steps != 0; remaining transitions loaded with cmd_steps*4; divider cleared.
  - IDLE -> FINISH on accept when cmd_steps == 0.
  - RUN: divider counts 0..STEP_DIV-1. On the terminal count, advance the quadrature phase one transition and decrement the remaining count. When the last transition is applied, go to FINISH.
  - FINISH: done = 1 for exactly one cycle, then IDLE; cmd_ready returns high in that IDLE cycle.
- Latency:
  - First A/B transition appears STEP_DIV cycles after the accept edge.
  - Subsequent transitions follow at STEP_DIV spacing.
  - done is asserted the cycle after the last transition.
- Quadrature sequence {B,A}, one detent = 4 transitions, rest state 00:
  - CW: 00 -> 01 -> 11 -> 10 -> 00.
  - CCW: 00 -> 10 -> 11 -> 01 -> 00.
  - Exactly one of A/B changes per transition.
  - Phase is a 2-bit Gray counter, +1 for CW, -1 for CCW, wrapping mod 4.
- Step-count width: the transition counter is CNT_WIDTH+2 bits, so cmd_steps = 2^CNT_WIDTH-1 does not overflow.
- BTN/SWT:
  - enc_out[2] and enc_out[3] are registered copies of btn_in and sw_in (1-cycle latency).
  - They are independent of the FSM and update in all states, including during RUN.
- All outputs come directly from flops; there are no combinational paths from inputs to enc_out.

Optional Feature:
- Macro: ENC_BOUNCE_EN.
- Defined:
  - Each A/B transition is emitted as a contact-bounce burst on the changing line only: new, old, new, held.
  - Successive levels are spaced BOUNCE_CYC cycles apart, starting at the divider terminal count.
  - The other line does not move during the burst.
  - The final settled sequence and done timing are unchanged.
- Undefined: clean single-edge transitions; BOUNCE_CYC is unused.

Decomposition:
- Package pmod_enc_pkg holds:
  - FSM state encodings IDLE/RUN/FINISH.
  - enc_out bit indices ENC_A=0, ENC_B=1, ENC_BTN=2, ENC_SWT=3.
  - The Gray phase-to-{B,A} lookup constants.
- One sub-module, enc_tick_div: a STEP_DIV strobe generator with synchronous active-low clear, reused later by the reader-side debounce.

Test Plan (STEP_DIV=4, CNT_WIDTH=8, BOUNCE_CYC=1 unless noted):
- Reset hold 3 cycles with btn_in=1 -> enc_out=0000, cmd_ready=1, busy=0, done=0. After release, enc_out[2]=1 one cycle later.
- CW, cmd_steps=2 -> {B,A} sequence 01,11,10,00,01,11,10,00. Transitions at accept+4, +8 ... +32; done pulses once at accept+33; cmd_ready high at accept+34.
- CCW, cmd_steps=1 -> 10,11,01,00 at 4-cycle spacing; exactly one bit changes per transition; single done pulse.
- cmd_steps=0 -> busy for 1 cycle, done at accept+1, A/B stay 00.
- New cmd_valid asserted during RUN -> ignored, cmd_ready=0. Then rst=0 after the 3rd transition -> enc_out=0000 next edge, busy=0, no done pulse.
- ENC_BOUNCE_EN, STEP_DIV=8, BOUNCE_CYC=2, CW 1 step -> A toggles 0,1,0,1 at 2-cycle spacing before settling. B is constant during A's burst. Final sequence and done timing match the clean build.

Source files
------------

// File: rtl/pmod_enc_pkg.sv
// Shared constants for the Pmod ENC generator: FSM encodings, enc_out bit map
// and the Gray phase to {B,A} lookup.
package pmod_enc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam int ENC_A   = 0;
  localparam int ENC_B   = 1;
  localparam int ENC_BTN = 2;
  localparam int ENC_SWT = 3;

  // Phase k -> {B,A}; rest state is phase 0
  localparam logic [1:0] PH0_BA = 2'b00;
  localparam logic [1:0] PH1_BA = 2'b01;
  localparam logic [1:0] PH2_BA = 2'b11;
  localparam logic [1:0] PH3_BA = 2'b10;

  function automatic logic [1:0] phase_to_ba(input logic [1:0] ph);
    logic [1:0] ba;
    case (ph)
      2'd0:    ba = PH0_BA;
      2'd1:    ba = PH1_BA;
      2'd2:    ba = PH2_BA;
      default: ba = PH3_BA;
    endcase
    return ba;
  endfunction

endpackage

// File: rtl/enc_tick_div.sv
// Divide-by-STEP_DIV strobe: o_tick is high on the cycle the counter sits at
// STEP_DIV-1 while enabled. i_clr_n is a synchronous active-low clear.
module enc_tick_div #(
  parameter int STEP_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(STEP_DIV - 1);

  logic [15:0] r_cnt;
  logic        w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en & w_last;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= w_last ? '0 : r_cnt + 16'd1;
  end

endmodule

// File: rtl/pmod_enc_gen.sv
// Quadrature rotary-encoder generator driving the Pmod ENC pin group.
// Define ENC_BOUNCE_EN to emit each A/B edge as a new/old/new contact-bounce burst.
module pmod_enc_gen
  import pmod_enc_pkg::*;
#(
  parameter int STEP_DIV   = 1000,
  parameter int CNT_WIDTH  = 8,
  parameter int BOUNCE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_steps,
  input  logic                 btn_in,
  input  logic                 sw_in,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           enc_out
);

  localparam int RW = CNT_WIDTH + 2;

  if (STEP_DIV < 2 || STEP_DIV > 65535 || 3 * BOUNCE_CYC >= STEP_DIV) begin : g_param_chk
    $error("pmod_enc_gen: STEP_DIV or BOUNCE_CYC out of range");
  end

  logic [1:0]    r_state;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_dir;
  logic [RW-1:0] r_rem;
  logic [1:0]    r_phase;
  logic [1:0]    r_ab;
  logic          r_btn;
  logic          r_sw;

  logic          w_accept;
  logic          w_tick;
  logic          w_step;
  logic          w_div_clr_n;
  logic [1:0]    w_phase_nxt;

  // cmd_ready is only ever high in IDLE, so it alone qualifies the accept
  assign w_accept    = cmd_valid & r_ready;
  assign w_div_clr_n = rst & ~w_accept;
  assign w_step      = (r_state == ST_RUN) & w_tick;
  assign w_phase_nxt = r_dir ? r_phase + 2'd1 : r_phase - 2'd1;

  enc_tick_div #(
    .STEP_DIV (STEP_DIV)
  ) u_div (
    .i_clk   (clk),
    .i_clr_n (w_div_clr_n),
    .i_en    (r_state == ST_RUN),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_phase <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_dir   <= cmd_dir;
            r_rem   <= {cmd_steps, 2'b00};
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= (cmd_steps != '0) ? ST_RUN : ST_FINISH;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            r_phase <= w_phase_nxt;
            r_rem   <= r_rem - 1'b1;
            if (r_rem == RW'(1))
              r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          // ready is withheld for this done cycle and rises in the following IDLE cycle
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENC_BOUNCE_EN
  localparam logic [15:0] BNC_LAST = 16'(BOUNCE_CYC - 1);

  logic [1:0]  r_bnc_left;
  logic [15:0] r_bnc_cnt;
  logic [1:0]  r_bnc_mask;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ab       <= 2'b00;
      r_bnc_left <= 2'd0;
      r_bnc_cnt  <= '0;
      r_bnc_mask <= 2'b00;
    end else if (w_step) begin
      r_ab       <= phase_to_ba(w_phase_nxt);
      r_bnc_mask <= phase_to_ba(w_phase_nxt) ^ phase_to_ba(r_phase);
      r_bnc_left <= 2'd2;
      r_bnc_cnt  <= '0;
    end else if (r_bnc_left != 2'd0) begin
      // Gray step: the mask holds only the moving line, so the other stays put
      if (r_bnc_cnt == BNC_LAST) begin
        r_ab       <= r_ab ^ r_bnc_mask;
        r_bnc_left <= r_bnc_left - 2'd1;
        r_bnc_cnt  <= '0;
      end else begin
        r_bnc_cnt  <= r_bnc_cnt + 16'd1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst)
      r_ab <= 2'b00;
    else if (w_step)
      r_ab <= phase_to_ba(w_phase_nxt);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_btn <= 1'b0;
      r_sw  <= 1'b0;
    end else begin
      r_btn <= btn_in;
      r_sw  <= sw_in;
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

  always_comb begin
    enc_out          = 4'b0000;
    enc_out[ENC_A]   = r_ab[0];
    enc_out[ENC_B]   = r_ab[1];
    enc_out[ENC_BTN] = r_btn;
    enc_out[ENC_SWT] = r_sw;
  end

endmodule

// File: tb/tb_pmod_enc_gen.sv
// Bench for pmod_enc_gen: directed and random commands against a cycle-indexed
// reference of the quadrature output; honours ENC_BOUNCE_EN.
module tb_pmod_enc_gen;

`ifdef ENC_BOUNCE_EN
  localparam int SD = 8;
  localparam int BC = 2;
`else
  localparam int SD = 4;
  localparam int BC = 1;
`endif

  // {B,A} for each quarter-turn position, clockwise order
  localparam logic [1:0] SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = 8'd0;
  logic       btn_in = 1'b0;
  logic       sw_in = 1'b0;
  logic       cmd_ready, busy, done;
  logic [3:0] enc_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pmod_enc_gen #(
    .STEP_DIV   (SD),
    .CNT_WIDTH  (8),
    .BOUNCE_CYC (BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .btn_in    (btn_in),
    .sw_in     (sw_in),
    .busy      (busy),
    .done      (done),
    .enc_out   (enc_out)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Position index after n transitions from rest, n capped at the commanded count
  function automatic int pos_idx(input logic dir, input int n);
    return dir ? (n % 4) : ((4 - (n % 4)) % 4);
  endfunction

  // Expected {B,A} in the k-th cycle after the accept edge
  function automatic logic [1:0] model_ab(input logic dir, input int steps, input int k);
    int n;
    logic [1:0] ab;
    n = k / SD;
    if (n > 4 * steps) n = 4 * steps;
    ab = SEQ[pos_idx(dir, n)];
`ifdef ENC_BOUNCE_EN
    if (n >= 1 && (k - n * SD) >= BC && (k - n * SD) < 2 * BC)
      ab = SEQ[pos_idx(dir, n - 1)];
`endif
    return ab;
  endfunction

  task automatic step_misc();
    chk("btn", {3'b000, enc_out[2]}, {3'b000, btn_in});
    chk("sw", {3'b000, enc_out[3]}, {3'b000, sw_in});
    btn_in = 1'($urandom);
    sw_in  = 1'($urandom);
  endtask

  task automatic run_cmd(input logic dir, input int steps);
    int tt;
    tt = 4 * steps * SD;
    chk("ready_before_cmd", {3'b000, cmd_ready}, 4'b0001);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = 8'(steps);
    for (int k = 0; k <= tt + 2; k++) begin
      @(negedge clk);
      chk($sformatf("ab dir=%0d steps=%0d k=%0d", dir, steps, k),
          {2'b00, enc_out[1:0]}, {2'b00, model_ab(dir, steps, k)});
      chk($sformatf("busy k=%0d", k), {3'b000, busy}, {3'b000, k <= tt});
      chk($sformatf("done k=%0d", k), {3'b000, done}, {3'b000, k == tt + 1});
      chk($sformatf("ready k=%0d", k), {3'b000, cmd_ready}, {3'b000, k >= tt + 2});
      step_misc();
      if (k < tt) begin
        cmd_valid = 1'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_steps = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_gap();
    for (int i = 0; i < 2 * BC + 2; i++) begin
      @(negedge clk);
      chk("gap_idle", {1'b0, cmd_ready, busy, done}, 4'b0100);
      step_misc();
    end
    chk("gap_rest_ab", {2'b00, enc_out[1:0]}, 4'b0000);
  endtask

  initial begin
    rst    = 1'b0;
    btn_in = 1'b1;
    sw_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_enc", enc_out, 4'b0000);
    chk("reset_ctl", {1'b0, cmd_ready, busy, done}, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("btn_after_release", {3'b000, enc_out[2]}, 4'b0001);
    chk("ab_after_release", {2'b00, enc_out[1:0]}, 4'b0000);

    run_cmd(1'b1, 2);
    idle_gap();
    run_cmd(1'b0, 1);
    idle_gap();
    run_cmd(1'b1, 0);
    idle_gap();
    for (int r = 0; r < 6; r++) begin
      run_cmd(1'($urandom), int'($urandom_range(0, 3)));
      idle_gap();
    end
    run_cmd(1'b0, 255);
    idle_gap();

    // Reset in the middle of a command after the third transition
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd2;
    for (int k = 0; k <= 3 * SD; k++) begin
      @(negedge clk);
      chk($sformatf("mid_ab k=%0d", k), {2'b00, enc_out[1:0]}, {2'b00, model_ab(1'b1, 2, k)});
      chk($sformatf("mid_ready k=%0d", k), {3'b000, cmd_ready}, 4'b0000);
      step_misc();
      cmd_valid = 1'b1;
      cmd_dir   = 1'($urandom);
      cmd_steps = 8'($urandom);
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_enc i=%0d", i), enc_out, 4'b0000);
      chk($sformatf("rst_ctl i=%0d", i), {1'b0, cmd_ready, busy, done}, 4'b0100);
    end
    btn_in = 1'b1;
    sw_in  = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    chk("after_mid_rst_enc", enc_out, 4'b1100);
    chk("after_mid_rst_ctl", {1'b0, cmd_ready, busy, done}, 4'b0100);
    run_cmd(1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
